rsa_keygen_ctrl: RTL
====================

Name: rsa_keygen_ctrl

Overview:
- Top-level key-setup sequencer for the RSA engine.
- Accepts primes p, q and computes n = p*q and phi = (p-1)*(q-1).
- Drives the existing encryption-key generator through its start/finish interface to obtain public exponent e.
- Computes private exponent d = e^-1 mod phi with an iterative extended-Euclid unit, then presents n, e and d to the encryptor/decryptor with a done/error handshake.

Parameters:
- TIMEOUT_CYCLES, 4096, max cycles to wait for eg_finish before aborting.
- CNT_W, 13, width of the timeout/iteration counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- p  in  8  prime p, sampled on accepted start.
- q  in  8  prime q, sampled on accepted start.
- eg_start  out  1  start to encryption-key generator.
- eg_e  in  8  e from generator.
- eg_finish  in  1  generator finish (level, cleared by its start).
- busy  out  1  high from accepted start until done/error.
- done  out  1  one-cycle pulse, keys valid.
- error  out  1  one-cycle pulse, keys invalid.
- err_code  out  2  0 none, 1 bad input, 2 timeout, 3 no inverse/selfcheck fail; held until next start.
- n  out  16  modulus, held.
- e  out  16  public exponent, zero-extended, held.
- d  out  16  private exponent, held.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters 0. Reset mid-operation aborts immediately, with no done/error pulse.
- IDLE: on start=1, latch p, q; clear n, e, d, err_code; busy<=1; go to CHECK. start while busy is ignored.
- CHECK (1 cycle):
  - If p<2 or q<2 or p==q: error pulse, err_code=1, go to IDLE.
  - Else n<=p*q and phi<=(p-1)*(q-1) as 16-bit unsigned; go to EG_START.
- EG_START (1 cycle): eg_start=1, clear timeout counter; go to EG_WAIT. eg_start is high in this state only.
- EG_WAIT:
  - eg_finish is ignored in the first cycle after EG_START, because the generator clears it on that edge.
  - From the second cycle, eg_finish=1 latches e<=eg_e and goes to INV_INIT.
  - If e>=phi, go instead to ERROR with code 3.
  - If the counter reaches TIMEOUT_CYCLES, go to ERROR with code 2.
- INV_INIT: old_r=phi, r=e, old_t=0, t=1. old_t/t are 18-bit signed; old_r/r are 16-bit unsigned.
- INV_ITER, one iteration per cycle:
  - qt = old_r / r and rem = old_r % r, from the combinational divider.
  - (old_r, r) <= (r, rem).
  - (old_t, t) <= (t, old_t - qt*t).
  - Exit when r==0 at cycle start.
  - Iteration cap is 24; exceeding it gives ERROR code 3.
- INV_FIX (1 cycle):
  - If old_r != 1: ERROR code 3.
  - Else d <= old_t<0 ? old_t+phi : old_t.
  - Go to DONE (or SELFCHK if enabled).
- DONE: done pulse, busy<=0, go to IDLE.
- ERROR: error pulse, busy<=0, d<=0, go to IDLE.
- Outputs n, e, d are stable from the done pulse until the next accepted start.
- Simultaneous events: start arriving in the same cycle as the done/error pulse is ignored; busy is still 1 in that cycle.

Optional Feature:
- RSA_KEYGEN_SELFCHECK_EN defined: adds state SELFCHK between INV_FIX and DONE.
  - Computes (e*d) mod phi using a 32-bit product and the divider over 2 cycles.
  - Result !=1 gives ERROR code 3; otherwise DONE. Adds 2 cycles of latency.
- Not defined: INV_FIX goes directly to DONE and no multiplier is instantiated.

Decomposition:
- Shared package rsa_pkg holds:
  - FSM state enum: IDLE, CHECK, EG_START, EG_WAIT, INV_INIT, INV_ITER, INV_FIX, SELFCHK, DONE, ERROR.
  - err_code constants ERR_NONE, ERR_INPUT, ERR_TIMEOUT, ERR_NOINV.
  - Width constants KEY_W=16, PRIME_W=8.
  - INV_MAX_ITER=24.
- One natural sub-module, rsa_modinv: the extended-Euclid iterator with its own start/done/fail handshake. It instantiates the existing Division16.

Test Plan:
- p=11, q=13 → n=143, phi=120, e=7, d=103, done pulse once, err_code=0, busy low after done.
- p=5, q=7 → n=35, e=5, d=5; with RSA_KEYGEN_SELFCHECK_EN, done is 2 cycles later than without.
- p=1, q=13 → error pulse 2 cycles after start, err_code=1, eg_start never asserted.
- eg_finish held 0 → error at TIMEOUT_CYCLES after EG_START, err_code=2. Stale eg_finish=1 during the first EG_WAIT cycle must not be accepted.
- Assert rst during INV_ITER → all outputs 0 asynchronously. A new start after release gives the correct result with no spurious done.
- start pulses while busy and on the done cycle are ignored; a second start after busy=0 with p=5, q=7 gives the fresh result.

Source files
------------

// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types, widths and helpers for the RSA key-setup block
package rsa_pkg;

  localparam int KEY_W        = 16;
  localparam int PRIME_W      = 8;
  localparam int T_W          = 18;
  localparam int INV_MAX_ITER = 24;
  localparam int ITER_W       = 5;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    EG_START,
    EG_WAIT,
    INV_INIT,
    INV_ITER,
    INV_FIX,
    SELFCHK,
    DONE,
    ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_INPUT   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_NOINV   = 2'd3;

  // Bring a signed Bezout coefficient into the range [0, m).
  function automatic logic [KEY_W-1:0] fix_inverse(input logic signed [T_W-1:0] t,
                                                   input logic [KEY_W-1:0] m);
    logic signed [T_W-1:0] adj;
    adj = t;
    if (t[T_W-1]) begin
      adj = t + $signed({2'b00, m});
    end
    return adj[KEY_W-1:0];
  endfunction

endpackage

// File: rtl/Division16.sv
// rtl/Division16.sv - combinational 16-bit unsigned divider (quotient and remainder)
module Division16 (
  input  logic [15:0] dividend_i,
  input  logic [15:0] divisor_i,
  output logic [15:0] quotient_o,
  output logic [15:0] remainder_o
);

  // Divide by zero returns all-ones quotient and passes the dividend through.
  always_comb begin
    quotient_o  = 16'hFFFF;
    remainder_o = dividend_i;
    if (divisor_i != 16'd0) begin
      quotient_o  = dividend_i / divisor_i;
      remainder_o = dividend_i % divisor_i;
    end
  end

endmodule

// File: rtl/rsa_modinv.sv
// rtl/rsa_modinv.sv - iterative extended-Euclid unit, one division step per cycle
module rsa_modinv
  import rsa_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [KEY_W-1:0]      phi_i,
  input  logic [KEY_W-1:0]      e_i,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [KEY_W-1:0]      gcd_o,
  output logic signed [T_W-1:0] t_o
);

  localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(INV_MAX_ITER);

  logic                  active_q, active_d;
  logic [KEY_W-1:0]      old_r_q, old_r_d, r_q, r_d;
  logic signed [T_W-1:0] old_t_q, old_t_d, t_q, t_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [KEY_W-1:0]      qt, rem;

  Division16 u_div (
    .dividend_i  (old_r_q),
    .divisor_i   (r_q),
    .quotient_o  (qt),
    .remainder_o (rem)
  );

  assign gcd_o = old_r_q;
  assign t_o   = old_t_q;

  // Load on start, then step (old_r, r) and (old_t, t) until r hits zero or the cap.
  always_comb begin
    active_d = active_q;
    old_r_d  = old_r_q;
    r_d      = r_q;
    old_t_d  = old_t_q;
    t_d      = t_q;
    iter_d   = iter_q;
    done_o   = active_q && (r_q == '0);
    fail_o   = active_q && (r_q != '0) && (iter_q == ITER_CAP);
    if (start_i) begin
      active_d = 1'b1;
      old_r_d  = phi_i;
      r_d      = e_i;
      old_t_d  = '0;
      t_d      = T_W'(1);
      iter_d   = '0;
    end else if (done_o || fail_o) begin
      active_d = 1'b0;
    end else if (active_q) begin
      old_r_d = r_q;
      r_d     = rem;
      old_t_d = t_q;
      t_d     = old_t_q - ($signed({2'b00, qt}) * t_q);
      iter_d  = iter_q + 1'b1;
    end
  end

  // Iterator state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      old_r_q  <= '0;
      r_q      <= '0;
      old_t_q  <= '0;
      t_q      <= '0;
      iter_q   <= '0;
    end else begin
      active_q <= active_d;
      old_r_q  <= old_r_d;
      r_q      <= r_d;
      old_t_q  <= old_t_d;
      t_q      <= t_d;
      iter_q   <= iter_d;
    end
  end

endmodule

// File: rtl/rsa_keygen_ctrl.sv
// rtl/rsa_keygen_ctrl.sv - RSA key-setup sequencer; RSA_KEYGEN_SELFCHECK_EN adds an e*d mod phi check
module rsa_keygen_ctrl
  import rsa_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PRIME_W-1:0] p,
  input  logic [PRIME_W-1:0] q,
  output logic               eg_start,
  input  logic [PRIME_W-1:0] eg_e,
  input  logic               eg_finish,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [KEY_W-1:0]   n,
  output logic [KEY_W-1:0]   e,
  output logic [KEY_W-1:0]   d
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic [PRIME_W-1:0]    p_q, p_d, q_q, q_d;
  logic [KEY_W-1:0]      n_q, n_d, e_q, e_d, d_q, d_d, phi_q, phi_d;
  logic [1:0]            err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  inv_start, inv_done, inv_fail;
  logic [KEY_W-1:0]      inv_gcd;
  logic signed [T_W-1:0] inv_t;
  logic [KEY_W-1:0]      eg_e_ext;

`ifdef RSA_KEYGEN_SELFCHECK_EN
  logic [2*KEY_W-1:0]    prod_q, prod_d, sc_rem;
  logic                  sc_ph_q, sc_ph_d;
`endif

  assign eg_e_ext = {{(KEY_W-PRIME_W){1'b0}}, eg_e};
  assign n        = n_q;
  assign e        = e_q;
  assign d        = d_q;
  assign err_code = err_q;

  rsa_modinv u_modinv (
    .clk     (clk),
    .rst     (rst),
    .start_i (inv_start),
    .phi_i   (phi_q),
    .e_i     (e_q),
    .done_o  (inv_done),
    .fail_o  (inv_fail),
    .gcd_o   (inv_gcd),
    .t_o     (inv_t)
  );

  // Next-state and Moore outputs; done/error are pulses of their own states.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    n_d       = n_q;
    e_d       = e_q;
    d_d       = d_q;
    phi_d     = phi_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    inv_start = 1'b0;
    eg_start  = 1'b0;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    error     = 1'b0;
`ifdef RSA_KEYGEN_SELFCHECK_EN
    prod_d    = prod_q;
    sc_ph_d   = sc_ph_q;
    sc_rem    = prod_q % {{KEY_W{1'b0}}, phi_q};
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          p_d     = p;
          q_d     = q;
          n_d     = '0;
          e_d     = '0;
          d_d     = '0;
          err_d   = ERR_NONE;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((p_q < 8'd2) || (q_q < 8'd2) || (p_q == q_q)) begin
          err_d   = ERR_INPUT;
          state_d = ERROR;
        end else begin
          n_d     = {8'd0, p_q} * {8'd0, q_q};
          phi_d   = ({8'd0, p_q} - 16'd1) * ({8'd0, q_q} - 16'd1);
          state_d = EG_START;
        end
      end
      EG_START: begin
        eg_start = 1'b1;
        cnt_d    = '0;
        state_d  = EG_WAIT;
      end
      EG_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // cnt_q==0 marks the cycle in which the generator is still clearing finish.
        if ((cnt_q != '0) && eg_finish) begin
          e_d = eg_e_ext;
          if (eg_e_ext >= phi_q) begin
            err_d   = ERR_NOINV;
            state_d = ERROR;
          end else begin
            state_d = INV_INIT;
          end
        end else if (cnt_d == TIMEOUT_LIM) begin
          err_d   = ERR_TIMEOUT;
          state_d = ERROR;
        end
      end
      INV_INIT: begin
        inv_start = 1'b1;
        state_d   = INV_ITER;
      end
      INV_ITER: begin
        if (inv_fail) begin
          err_d   = ERR_NOINV;
          state_d = ERROR;
        end else if (inv_done) begin
          state_d = INV_FIX;
        end
      end
      INV_FIX: begin
        if (inv_gcd != 16'd1) begin
          err_d   = ERR_NOINV;
          state_d = ERROR;
        end else begin
          d_d = fix_inverse(inv_t, phi_q);
`ifdef RSA_KEYGEN_SELFCHECK_EN
          state_d = SELFCHK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef RSA_KEYGEN_SELFCHECK_EN
      SELFCHK: begin
        // First cycle forms the product, second reduces it modulo phi.
        if (!sc_ph_q) begin
          prod_d  = e_q * d_q;
          sc_ph_d = 1'b1;
        end else begin
          sc_ph_d = 1'b0;
          if (sc_rem == 32'd1) begin
            state_d = DONE;
          end else begin
            err_d   = ERR_NOINV;
            state_d = ERROR;
          end
        end
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERROR: begin
        error   = 1'b1;
        d_d     = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and key registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      n_q     <= '0;
      e_q     <= '0;
      d_q     <= '0;
      phi_q   <= '0;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      n_q     <= n_d;
      e_q     <= e_d;
      d_q     <= d_d;
      phi_q   <= phi_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef RSA_KEYGEN_SELFCHECK_EN
  // Self-check product and phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      sc_ph_q <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      sc_ph_q <= sc_ph_d;
    end
  end
`endif

endmodule
